// File: rtl/pc_gen_unit_pkg.sv
// Shared types and helpers for the fetch-stage PC generator: FSM states,
// default vectors and target alignment.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    localparam int          XLEN_DEF      = 32;
    localparam int          PC_MAX_W      = 64;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0040_0004;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic                mis;
    } align_t;

    // Clears the low lsb bits of target and reports whether any were set.
    function automatic align_t align_pc(input logic [PC_MAX_W-1:0] target,
                                        input int unsigned lsb);
        logic [PC_MAX_W-1:0] mask;
        align_t              res;
        mask    = (PC_MAX_W'(1) << lsb) - PC_MAX_W'(1);
        res.pc  = target & ~mask;
        res.mis = |(target & mask);
        return res;
    endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch handshake between the PC generator (master) and instruction memory (slave).
interface pc_fetch_if
    import pc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            fetch_valid_o;
    logic [XLEN-1:0] fetch_pc_o;
    logic            fetch_ready_i;

    modport master (output fetch_valid_o, output fetch_pc_o, input fetch_ready_i);
    modport slave  (input fetch_valid_o, input fetch_pc_o, output fetch_ready_i);
endinterface

// File: rtl/pc_gen_unit_pend_buf.sv
// Deferred-redirect buffer: holds the raw target of the latest redirect seen under stall.
module pc_pend_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clr,
    input  logic [XLEN-1:0] target_in,
    output logic [XLEN-1:0] target,
    output logic            valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= '0;
            valid  <= 1'b0;
        end else if (clr) begin
            valid  <= 1'b0;
        end else if (load) begin
            target <= target_in;
            valid  <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator with stall-deferred redirects.
// Optional exception entry/return is enabled by defining PC_EXC_EN.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEF),
    parameter int              INC       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redir_valid_i,
    input  logic [XLEN-1:0]   redir_pc_i,
    input  logic              exc_i,
    input  logic              eret_i,
    pc_fetch_if.master        fetch,
    output logic              redir_pend_o,
    output logic              align_err_o,
    output logic [XLEN-1:0]   epc_o
);

    localparam int unsigned INC_LSB = $clog2(INC);

    pc_state_e       state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            align_nxt;
    logic            buf_load, buf_clr, buf_valid;
    logic [XLEN-1:0] buf_target;
    align_t          redir_al, buf_al;

    pc_pend_buf #(.XLEN(XLEN)) u_pend_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clr       (buf_clr),
        .target_in (redir_pc_i),
        .target    (buf_target),
        .valid     (buf_valid)
    );

    assign fetch.fetch_pc_o    = pc;
    assign fetch.fetch_valid_o = (state != BOOT);
    assign redir_pend_o        = buf_valid;

`ifdef PC_EXC_EN
    logic [XLEN-1:0] epc_nxt;
`else
    logic exc_unused;
    assign exc_unused = exc_i | eret_i;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        align_nxt = 1'b0;
        buf_load  = 1'b0;
        buf_clr   = 1'b0;
`ifdef PC_EXC_EN
        epc_nxt   = epc_o;
`endif
        redir_al  = align_pc(PC_MAX_W'(redir_pc_i), INC_LSB);
        buf_al    = align_pc(PC_MAX_W'(buf_target), INC_LSB);

        if (state == BOOT) begin
            state_nxt = RUN;
        end else begin
`ifdef PC_EXC_EN
            if (exc_i) begin
                epc_nxt   = pc;
                pc_nxt    = EXC_VEC;
                buf_clr   = 1'b1;
                state_nxt = RUN;
            end else if (eret_i) begin
                // Leaving for RUN, so a stale deferred target must not linger.
                pc_nxt    = epc_o;
                buf_clr   = 1'b1;
                state_nxt = RUN;
            end else
`endif
            if (redir_valid_i && stall_i) begin
                buf_load  = 1'b1;
                state_nxt = PEND;
            end else if (redir_valid_i) begin
                // A fresh redirect supersedes anything buffered.
                pc_nxt    = XLEN'(redir_al.pc);
                align_nxt = redir_al.mis;
                buf_clr   = 1'b1;
                state_nxt = RUN;
            end else if (state == PEND && !stall_i) begin
                pc_nxt    = XLEN'(buf_al.pc);
                align_nxt = buf_al.mis;
                buf_clr   = 1'b1;
                state_nxt = RUN;
            end else if (state == RUN && !stall_i && fetch.fetch_ready_i) begin
                pc_nxt    = pc + XLEN'(INC);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_VEC;
            align_err_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            align_err_o <= align_nxt;
        end
    end

`ifdef PC_EXC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) epc_o <= '0;
        else     epc_o <= epc_nxt;
    end
`else
    assign epc_o = '0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed plus randomized check of pc_gen_unit against a behavioural PC model.
module tb_pc_gen_unit;

    localparam logic [31:0] RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC   = 32'h0040_0004;
    localparam int          INC       = 4;
`ifdef PC_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk, rst;
    logic        stall, redir_valid, exc, eret;
    logic [31:0] redir_pc;
    logic        redir_pend, align_err;
    logic [31:0] epc;

    pc_fetch_if #(.XLEN(32)) fetch_bus ();

    pc_gen_unit #(
        .XLEN(32), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC), .INC(INC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redir_valid_i (redir_valid),
        .redir_pc_i    (redir_pc),
        .exc_i         (exc),
        .eret_i        (eret),
        .fetch         (fetch_bus),
        .redir_pend_o  (redir_pend),
        .align_err_o   (align_err),
        .epc_o         (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_run, m_pend, m_err;
    logic [31:0] m_pc, m_epc, m_tgt;

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_err = 0;
        m_pc = RESET_VEC; m_epc = 0; m_tgt = 0;
    endtask

    task automatic apply_target(input logic [31:0] t);
        m_err = (t % INC) != 0;
        m_pc  = t - (t % INC);
    endtask

    task automatic model_step();
        if (!m_run) begin
            m_run = 1; m_err = 0;
        end else begin
            m_err = 0;
            if (EXC_EN && exc) begin
                m_epc = m_pc; m_pc = EXC_VEC; m_pend = 0;
            end else if (EXC_EN && eret) begin
                m_pc = m_epc; m_pend = 0;
            end else if (redir_valid && stall) begin
                m_pend = 1; m_tgt = redir_pc;
            end else if (redir_valid) begin
                apply_target(redir_pc); m_pend = 0;
            end else if (m_pend && !stall) begin
                apply_target(m_tgt); m_pend = 0;
            end else if (!m_pend && !stall && fetch_bus.fetch_ready_i) begin
                m_pc = m_pc + INC;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pc"},    fetch_bus.fetch_pc_o,           m_pc);
        check({tag, "_valid"}, 32'(fetch_bus.fetch_valid_o),   32'(m_run));
        check({tag, "_pend"},  32'(redir_pend),                32'(m_pend));
        check({tag, "_aerr"},  32'(align_err),                 32'(m_err));
        check({tag, "_epc"},   epc,                            m_epc);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input bit s, input bit r, input logic [31:0] t);
        stall = s; redir_valid = r; redir_pc = t;
    endtask

    initial begin
        rst = 1; stall = 0; redir_valid = 0; redir_pc = 0; exc = 0; eret = 0;
        fetch_bus.fetch_ready_i = 1;
        model_reset();
        #3;
        check_all("reset");
        check("reset_pc_const", fetch_bus.fetch_pc_o, 32'h0040_0000);
        @(negedge clk) rst = 0;

        // sequential fetch out of BOOT
        cycle("boot");
        check("boot_valid_const", 32'(fetch_bus.fetch_valid_o), 32'd1);
        cycle("seq1");
        cycle("seq2");
        check("seq_pc_const", fetch_bus.fetch_pc_o, 32'h0040_0008);

        // IMEM back-pressure holds PC
        fetch_bus.fetch_ready_i = 0;
        repeat (3) cycle("hold");
        check("hold_pc_const", fetch_bus.fetch_pc_o, 32'h0040_0008);
        fetch_bus.fetch_ready_i = 1;
        cycle("resume");
        check("resume_pc_const", fetch_bus.fetch_pc_o, 32'h0040_000C);

        // redirect under stall is deferred
        set_in(1, 1, 32'h0040_0100);
        cycle("defer");
        set_in(1, 0, 0);
        cycle("stall1");
        cycle("stall2");
        check("pend_const", 32'(redir_pend), 32'd1);
        check("frozen_pc_const", fetch_bus.fetch_pc_o, 32'h0040_000C);
        set_in(0, 0, 0);
        cycle("release");
        check("release_pc_const", fetch_bus.fetch_pc_o, 32'h0040_0100);

        // latest deferred redirect wins
        set_in(1, 1, 32'h0040_0180);
        cycle("pend_a");
        set_in(1, 1, 32'h0040_0200);
        cycle("pend_b");
        set_in(0, 0, 0);
        cycle("latest");
        check("latest_pc_const", fetch_bus.fetch_pc_o, 32'h0040_0200);

        // misaligned direct redirect
        set_in(0, 1, 32'h0040_0102);
        cycle("mis");
        check("mis_aerr_const", 32'(align_err), 32'd1);
        set_in(0, 0, 0);
        cycle("mis_after");
        check("mis_pulse_const", 32'(align_err), 32'd0);

        // misaligned buffered redirect, then redirect beating the buffer
        set_in(1, 1, 32'h0040_0303);
        cycle("bmis_a");
        set_in(0, 0, 0);
        cycle("bmis_b");
        set_in(1, 1, 32'h0040_0400);
        cycle("win_a");
        set_in(0, 1, 32'h0040_0500);
        cycle("win_b");
        check("win_pc_const", fetch_bus.fetch_pc_o, 32'h0040_0500);

        // exception entry/return (ignored when the feature is compiled out)
        set_in(0, 1, 32'h0040_0010);
        cycle("exc_setup");
        set_in(0, 0, 0);
        fetch_bus.fetch_ready_i = 0;
        exc = 1;
        cycle("exc");
        exc = 0;
`ifdef PC_EXC_EN
        check("exc_pc_const", fetch_bus.fetch_pc_o, 32'h0040_0004);
        check("exc_epc_const", epc, 32'h0040_0010);
`else
        check("exc_ignored_epc", epc, 32'h0);
`endif
        eret = 1;
        cycle("eret");
        eret = 0;
        check("eret_pc_const", fetch_bus.fetch_pc_o, 32'h0040_0010);
        exc = 1; eret = 1;
        cycle("exc_eret");
        exc = 0; eret = 0;
        set_in(1, 1, 32'h0040_0700);
        cycle("exc_pend_a");
        exc = 1; set_in(1, 0, 0);
        cycle("exc_pend_b");
        exc = 0; set_in(0, 0, 0);
        fetch_bus.fetch_ready_i = 1;
        cycle("exc_pend_c");

        // PC wraps silently
        set_in(0, 1, 32'hFFFF_FFFC);
        cycle("wrap_a");
        set_in(0, 0, 0);
        cycle("wrap_b");
        check("wrap_pc_const", fetch_bus.fetch_pc_o, 32'h0);

        // async reset while a redirect is pending
        set_in(1, 1, 32'h0040_0800);
        cycle("arst_pend");
        set_in(1, 0, 0);
        #2 rst = 1;
        model_reset();
        #1;
        check_all("arst");
        check("arst_pc_const", fetch_bus.fetch_pc_o, 32'h0040_0000);
        check("arst_pend_const", 32'(redir_pend), 32'd0);
        @(negedge clk) rst = 0;
        set_in(0, 0, 0);
        cycle("arst_boot");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            fetch_bus.fetch_ready_i = $urandom_range(0, 1);
            redir_valid = ($urandom_range(0, 4) == 0);
            redir_pc = ($urandom_range(0, 3) == 0) ? $urandom
                                                   : 32'h0040_0000 + $urandom_range(0, 1023);
            exc  = ($urandom_range(0, 30) == 0);
            eret = ($urandom_range(0, 30) == 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
